framebuffer_drawer: RTL

//   Parametrised, double-buffered framebuffer overlay for the VGA display path. Accepts a

---
 rtl/framebuffer_drawer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/framebuffer_drawer.sv
// Double-buffered image overlay for the VGA path: a raster pixel stream fills the back bank,
// the banks swap on a display frame boundary, and the front bank is drawn scaled into a window.
module framebuffer_drawer #(
   parameter int IMG_W         = 128,
   parameter int IMG_H         = 128,
   parameter int SCALE_LOG2    = 1,
   parameter int ORIGIN_X      = 242,
   parameter int ORIGIN_Y      = 112,
   parameter int BITS_PER_CH   = 4,
   parameter int DOUBLE_BUFFER = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [8:0]  row,
   input  logic [9:0]  column,
   input  logic        frame_start,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [23:0] wr_color,
   input  logic        wr_restart,
   output logic        frame_done,
   output logic        front_bank
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam int AW = XW + YW;
   localparam int CW = BITS_PER_CH;
   localparam int DW = 3 * CW;

   localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);
   localparam logic [10:0]   X_LO = 11'(ORIGIN_X);
   localparam logic [10:0]   X_HI = 11'(ORIGIN_X + (IMG_W << SCALE_LOG2));
   localparam logic [10:0]   Y_LO = 11'(ORIGIN_Y);
   localparam logic [10:0]   Y_HI = 11'(ORIGIN_Y + (IMG_H << SCALE_LOG2));

   localparam logic [0:0] ST_FILL      = 1'b0;
   localparam logic [0:0] ST_WAIT_SWAP = 1'b1;

   // Keep the top CW bits of each 8-bit channel.
   function automatic logic [DW-1:0] pack_color(input logic [23:0] c);
      pack_color = {c[23 -: CW], c[15 -: CW], c[7 -: CW]};
   endfunction

   // Widen a stored channel by repeating its bits MSB-first (4'hA -> 8'hAA).
   function automatic logic [7:0] expand(input logic [CW-1:0] ch);
      expand = '0;
      for (int i = 0; i < 8; i++) expand[7-i] = ch[CW-1-(i % CW)];
   endfunction

   logic [DW-1:0] mem [0:(2 << AW)-1];

   logic [0:0]    state;
   logic [AW-1:0] wr_ptr;
   logic          wr_bank;
   logic          accept;

   assign wr_ready = (state == ST_FILL) && !wr_restart;
   assign accept   = wr_valid && wr_ready;
   assign wr_bank  = (DOUBLE_BUFFER != 0) ? ~front_bank : 1'b0;

   // NOTE: all sequential state uses non-blocking assignments so every register samples
   // pre-edge values; a blocking write here would let the read port see same-cycle data.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_FILL;
         wr_ptr     <= '0;
         front_bank <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (wr_restart) begin
            wr_ptr <= '0;
            state  <= ST_FILL;
         end else if (accept) begin
            if (wr_ptr == LAST_ADDR) begin
               wr_ptr     <= '0;
               frame_done <= 1'b1;
               if (DOUBLE_BUFFER != 0) state <= ST_WAIT_SWAP;
            end else begin
               wr_ptr <= wr_ptr + AW'(1);
            end
         end else if ((state == ST_WAIT_SWAP) && frame_start) begin
            front_bank <= ~front_bank;
            state      <= ST_FILL;
         end
      end
   end

   // NOTE: the pixel RAM has no reset; clearing it would defeat block-RAM inference,
   // and the window is only trusted once a complete image has been swapped in.
   always_ff @(posedge clk) begin
      if (accept) mem[{wr_bank, wr_ptr}] <= pack_color(wr_color);
   end

   // Read stage 0: window test and image address from the scan position.
   logic [10:0]   col_x, row_y;
   logic [XW-1:0] img_x;
   logic [YW-1:0] img_y;
   logic          in_range;

   assign col_x    = {1'b0, column};
   assign row_y    = {2'b00, row};
   assign img_x    = XW'((col_x - X_LO) >> SCALE_LOG2);
   assign img_y    = YW'((row_y - Y_LO) >> SCALE_LOG2);
   assign in_range = (col_x >= X_LO) && (col_x < X_HI) && (row_y >= Y_LO) && (row_y < Y_HI);

   logic [DW-1:0] rd_data;
   logic          in_range_d;

   always_ff @(posedge clk) begin
      rd_data <= mem[{front_bank, img_y, img_x}];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_range_d <= 1'b0;
         red        <= '0;
         green      <= '0;
         blue       <= '0;
      end else begin
         in_range_d <= in_range;
         red        <= in_range_d ? expand(rd_data[DW-1 -: CW])   : 8'h00;
         green      <= in_range_d ? expand(rd_data[2*CW-1 -: CW]) : 8'h00;
         blue       <= in_range_d ? expand(rd_data[CW-1:0])       : 8'h00;
      end
   end

endmodule
